// File: rtl/sc_plateau_trigger.sv
// Schmidl & Cox plateau trigger: divider-free |P|^2 >= thr*R^2 test,
// plateau length qualifier, holdoff/re-arm, one CFO-tagged trigger per plateau.
// Ports: clk, reset_n (async low), clear (sync flush), set_stb/addr/data
// settings bus, i_t* AXIS in {p2,r2,phase}, o_t* AXIS out {trig,cfo},
// trig_count (wrapping trigger counter).
module sc_plateau_trigger #(
  parameter int BASE        = 0,
  parameter int MAG_W       = 64,
  parameter int PHASE_W     = 16,
  parameter int TFRAC       = 14,
  parameter int THR_DEFAULT = 15563
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic                       set_stb,
  input  logic [7:0]                 set_addr,
  input  logic [31:0]                set_data,
  input  logic [2*MAG_W+PHASE_W-1:0] i_tdata,
  input  logic                       i_tlast,
  input  logic                       i_tvalid,
  output logic                       i_tready,
  output logic [PHASE_W:0]           o_tdata,
  output logic                       o_tlast,
  output logic                       o_tvalid,
  input  logic                       o_tready,
  output logic [31:0]                trig_count
);
  localparam int CW = MAG_W + TFRAC;
  localparam logic [7:0] A_THR = 8'(BASE);
  localparam logic [7:0] A_LEN = 8'(BASE + 1);
  localparam logic [7:0] A_CFG = 8'(BASE + 2);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAT,
    ST_HOLD,
    ST_REARM
  } state_t;

  logic [TFRAC-1:0]   r_thr;
  logic [15:0]        r_min_len;
  logic [15:0]        r_holdoff;
  logic               r_enable;
  logic [3:0]         r_shift;

  logic               r_s1_vld;
  logic [CW-1:0]      r_s1_lhs;
  logic [CW-1:0]      r_s1_rhs;
  logic               r_s1_r2nz;
  logic [PHASE_W-1:0] r_s1_phase;
  logic               r_s1_last;

  state_t             r_state;
  logic [15:0]        r_cnt;
  logic [15:0]        r_hcnt;
  logic               r_ovld;
  logic               r_olast;
  logic               r_trig;
  logic [PHASE_W-1:0] r_cfo;
  logic [31:0]        r_tcnt;

  logic [MAG_W-1:0]   w_p2;
  logic [MAG_W-1:0]   w_r2;
  logic [PHASE_W-1:0] w_phase;
  logic               w_adv;
  logic               w_s2_fire;
  logic               w_above;
  logic [15:0]        w_min_eff;
  logic [PHASE_W-1:0] w_cfo;
  state_t             w_state_nxt;
  logic [15:0]        w_cnt_nxt;
  logic [15:0]        w_hcnt_nxt;
  logic               w_trig;

  assign w_p2    = i_tdata[2*MAG_W+PHASE_W-1 -: MAG_W];
  assign w_r2    = i_tdata[MAG_W+PHASE_W-1 -: MAG_W];
  assign w_phase = i_tdata[PHASE_W-1:0];

  // Whole pipeline moves in lockstep with the output register.
  assign w_adv     = !r_ovld || o_tready;
  assign i_tready  = w_adv;
  assign w_s2_fire = r_s1_vld && w_adv;

  assign o_tvalid   = r_ovld;
  assign o_tlast    = r_olast;
  assign o_tdata    = {r_trig, r_cfo};
  assign trig_count = r_tcnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_thr     <= TFRAC'(THR_DEFAULT);
      r_min_len <= 16'd16;
      r_holdoff <= 16'd64;
      r_enable  <= 1'b1;
      r_shift   <= 4'd4;
    end else if (set_stb) begin
      unique case (1'b1)
        set_addr == A_THR: r_thr <= set_data[TFRAC-1:0];
        set_addr == A_LEN: begin
          r_min_len <= set_data[15:0];
          r_holdoff <= set_data[31:16];
        end
        set_addr == A_CFG: begin
          r_enable <= set_data[0];
          r_shift  <= set_data[4:1];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_vld   <= 1'b0;
      r_s1_lhs   <= '0;
      r_s1_rhs   <= '0;
      r_s1_r2nz  <= 1'b0;
      r_s1_phase <= '0;
      r_s1_last  <= 1'b0;
    end else if (clear) begin
      r_s1_vld <= 1'b0;
    end else if (w_adv) begin
      r_s1_vld <= i_tvalid;
      if (i_tvalid) begin
        r_s1_lhs   <= {w_p2, {TFRAC{1'b0}}};
        r_s1_rhs   <= CW'(w_r2) * CW'(r_thr);
        r_s1_r2nz  <= |w_r2;
        r_s1_phase <= w_phase;
        r_s1_last  <= i_tlast;
      end
    end
  end

  assign w_above   = r_enable && r_s1_r2nz && (r_s1_lhs >= r_s1_rhs);
  assign w_min_eff = (r_min_len == 16'd0) ? 16'd1 : r_min_len;
  assign w_cfo     = $signed(r_s1_phase) >>> r_shift;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hcnt_nxt  = r_hcnt;
    w_trig      = 1'b0;
    if (!r_enable) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_above) begin
            if (w_min_eff == 16'd1) begin
              w_trig      = 1'b1;
              w_hcnt_nxt  = r_holdoff;
              w_state_nxt = ST_HOLD;
            end else begin
              w_cnt_nxt   = 16'd1;
              w_state_nxt = ST_PLAT;
            end
          end
        end
        ST_PLAT: begin
          if (!w_above) begin
            w_state_nxt = ST_IDLE;
          end else if ({1'b0, r_cnt} + 17'd1 == {1'b0, w_min_eff}) begin
            w_trig      = 1'b1;
            w_hcnt_nxt  = r_holdoff;
            w_state_nxt = ST_HOLD;
          end else begin
            w_cnt_nxt = r_cnt + 16'd1;
          end
        end
        ST_HOLD: begin
          if (r_hcnt == 16'd0) w_state_nxt = ST_REARM;
          else w_hcnt_nxt = r_hcnt - 16'd1;
        end
        ST_REARM: begin
          // Wait for the plateau to end so it cannot retrigger.
          if (!w_above) w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_hcnt  <= '0;
      r_ovld  <= 1'b0;
      r_olast <= 1'b0;
      r_trig  <= 1'b0;
      r_cfo   <= '0;
      r_tcnt  <= '0;
    end else if (clear) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_hcnt  <= '0;
      r_ovld  <= 1'b0;
      r_olast <= 1'b0;
      r_trig  <= 1'b0;
      r_cfo   <= '0;
      r_tcnt  <= '0;
    end else begin
      if (w_adv) r_ovld <= r_s1_vld;
      if (w_s2_fire) begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_hcnt  <= w_hcnt_nxt;
        r_olast <= r_s1_last;
        r_trig  <= w_trig;
        if (w_trig) begin
          r_cfo  <= w_cfo;
          r_tcnt <= r_tcnt + 32'd1;
        end
      end
    end
  end

endmodule

// File: doc/sc_plateau_trigger.md
Name: sc_plateau_trigger

Overview:
- Parametrised successor to the fixed-threshold plateau detector in the Schmidl & Cox synchroniser chain.
- Consumes a sample-aligned stream of correlation power |P|^2, energy R^2 and correlation phase, and tests |P|^2 >= thr*R^2 by cross-multiplication, so no divider core is needed.
- Detects plateaus of programmable minimum length, emits one trigger per plateau with a shifted CFO estimate, then applies a programmable holdoff and re-arm.
- Output feeds the phase accumulator / framer trigger path.

Parameters:
- BASE, 0, settings-bus base address.
- MAG_W, 64, width of the unsigned |P|^2 and R^2 inputs.
- PHASE_W, 16, width of the signed phase input and the CFO output.
- TFRAC, 14, threshold fraction bits; thr = set value / 2^TFRAC.
- THR_DEFAULT, 15563, reset value of the threshold register.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous flush: state machine to IDLE, pipeline emptied, registers kept
- set_stb  in  1  settings write strobe
- set_addr  in  8  settings address
- set_data  in  32  settings data
- i_tdata  in  2*MAG_W+PHASE_W  {p2, r2, phase}, phase in the LSBs
- i_tlast  in  1  passed through
- i_tvalid  in  1  AXI-stream valid
- i_tready  out  1  AXI-stream ready
- o_tdata  out  PHASE_W+1  {trig, cfo}
- o_tlast  out  1  delayed i_tlast
- o_tvalid  out  1  AXI-stream valid
- o_tready  in  1  AXI-stream ready
- trig_count  out  32  number of triggers since reset or clear; wraps

Behaviour:
Reset and clear
- Asynchronous reset: o_tvalid=0, o_tdata=0, o_tlast=0, trig_count=0, state IDLE.
- Registers reset to: thr=THR_DEFAULT, min_len=16, holdoff=64, enable=1, shift=4.
- clear: same as reset except the settings registers keep their values.

Settings
- BASE+0: thr[TFRAC-1:0].
- BASE+1: min_len[15:0], holdoff[31:16].
- BASE+2: bit0 enable, bits[4:1] shift.
- Writes take effect on the next accepted sample.
- min_len=0 is treated as 1.

Pipeline
- Two registered stages:
  - S1 registers lhs=p2<<TFRAC (MAG_W+TFRAC bits) and rhs=r2*thr (MAG_W+TFRAC bits).
  - S2 evaluates the compare and the FSM, and registers the output.
- Latency is exactly 2 cycles from an i_tvalid&&i_tready transfer to o_tvalid when o_tready is held high.
- The whole pipeline advances only when the output register is empty or o_tready=1.
- i_tready = !o_tvalid || o_tready.
- One output beat per input beat; no drops, no insertion.
- o_tdata and o_tlast are stable while o_tvalid=1 and o_tready=0.

Compare
- above = enable && (r2 != 0) && (lhs >= rhs), all unsigned.
- r2=0 always gives above=0.

FSM (advances once per accepted sample, in S2)
- IDLE:
  - above → cnt=1, go to PLAT.
  - If min_len_eff=1, trigger immediately on this sample instead (same action as the PLAT trigger below).
- PLAT:
  - !above → IDLE.
  - above and cnt+1 == min_len_eff → trigger on this sample, load hcnt=holdoff, go to HOLD.
  - Otherwise cnt++.
- HOLD:
  - hcnt==0 → REARM.
  - Otherwise hcnt--.
  - Input is ignored.
- REARM: go to IDLE on the first sample with !above, which ends the plateau and prevents a retrigger inside it.
- enable=0 forces IDLE on the next sample.

Trigger sample
- trig=1 for exactly that output beat.
- cfo register = phase >>> shift (arithmetic) for that sample; the new value is visible in the same beat.
- trig_count increments.
- On all other beats trig=0 and cfo holds its last value.
- trig_count wraps 0xFFFFFFFF → 0.

Test Plan:
- After reset with o_tready=1, 8 beats of p2=0, r2=100 → 8 output beats each exactly 2 cycles after input, trig=0, cfo=0, trig_count=0.
- min_len=16, holdoff=64, thr=15563. 40 beats of p2=r2=2^20 with phase=0x0400 → single trig on the 16th beat, cfo=0x0040, trig_count=1, no retrigger on beats 17..40.
- Same plateau held for 200 beats, then 1 low beat, then 20 high beats → exactly 2 triggers total, the second on the 16th beat after the low beat.
- Plateau of 15 beats, then 1 low beat, repeated 4 times → no trigger. Boundary check: p2*2^14 == r2*thr is above=1; one less is above=0.
- r2=0 with p2=max → never above. phase=0x8000 with shift=4 → cfo=0xF800 (sign kept).
- Random o_tready backpressure (30% low) over 1000 beats → output equals the unstalled reference stream beat-for-beat, and tlast is aligned. Reset_n asserted mid-plateau → all outputs 0 immediately, and no trigger after release until a fresh 16-beat plateau.
